// File: rtl/dcache_pkg.sv
// Shared types, geometry constants and the byte-merge helper for the data cache.
package dcache_pkg;

    localparam int TAG_W      = 3;
    localparam int INDEX_W    = 3;
    localparam int OFFSET_W   = 2;
    localparam int ADDR_W     = TAG_W + INDEX_W + OFFSET_W;
    localparam int MEM_ADDR_W = TAG_W + INDEX_W;
    localparam int SETS       = 1 << INDEX_W;
    localparam int BLOCK_W    = 32;
    localparam int BYTE_W     = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2
    } state_t;

    // Replace one byte of a block, leaving the other three untouched.
    function automatic logic [BLOCK_W-1:0] merge_byte(
        input logic [BLOCK_W-1:0]  block,
        input logic [OFFSET_W-1:0] offset,
        input logic [BYTE_W-1:0]   data
    );
        logic [BLOCK_W-1:0] merged;
        merged = block;
        case (offset)
            2'd0:    merged[7:0]   = data;
            2'd1:    merged[15:8]  = data;
            2'd2:    merged[23:16] = data;
            2'd3:    merged[31:24] = data;
            default: merged        = block;
        endcase
        return merged;
    endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side and memory-side signals of the data cache, bundled for port hookup.
interface dcache_if;
    import dcache_pkg::*;

    logic                  read;
    logic                  write;
    logic [ADDR_W-1:0]     address;
    logic [BYTE_W-1:0]     writedata;
    logic [BYTE_W-1:0]     readdata;
    logic                  busywait;
    logic                  mem_read;
    logic                  mem_write;
    logic [MEM_ADDR_W-1:0] mem_address;
    logic [BLOCK_W-1:0]    mem_writedata;
    logic [BLOCK_W-1:0]    mem_readdata;
    logic                  mem_busywait;

    // Environment side: drives CPU requests and memory responses.
    modport master (
        output read, write, address, writedata, mem_readdata, mem_busywait,
        input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
    );

    // Cache controller side.
    modport slave (
        input  read, write, address, writedata, mem_readdata, mem_busywait,
        output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
    );

endinterface

// File: rtl/dcache_byte_sel.sv
// Combinational 32-to-8 byte selector; outputs zero while disabled.
module dcache_byte_sel
    import dcache_pkg::*;
(
    input  logic [BLOCK_W-1:0]  block,
    input  logic [OFFSET_W-1:0] offset,
    input  logic                en,
    output logic [BYTE_W-1:0]   sel_byte
);

    // Pick the addressed byte, offset 0 being the least significant.
    always_comb begin
        sel_byte = 8'h00;
        if (en) begin
            case (offset)
                2'd0:    sel_byte = block[7:0];
                2'd1:    sel_byte = block[15:8];
                2'd2:    sel_byte = block[23:16];
                2'd3:    sel_byte = block[31:24];
                default: sel_byte = 8'h00;
            endcase
        end else begin
            sel_byte = 8'h00;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits are served combinationally in IDLE; misses walk WRITEBACK (if dirty)
// and FETCH while busywait stalls the CPU, which holds its request stable.
module dcache_controller
    import dcache_pkg::*;
(
    input logic     clock,
    input logic     reset,
    dcache_if.slave bus
);

    logic [TAG_W-1:0]      tag_s;
    logic [INDEX_W-1:0]    index_s;
    logic [OFFSET_W-1:0]   offset_s;

    logic [SETS-1:0]       valid_r;
    logic [SETS-1:0]       dirty_r;
    logic [TAG_W-1:0]      tag_array_r  [SETS];
    logic [BLOCK_W-1:0]    data_array_r [SETS];

    state_t                state_r;
    state_t                state_s;

    logic                  hit_s;
    logic                  access_s;
    logic                  idle_hit_s;
    logic                  write_hit_s;
    logic                  refill_s;
    logic                  rd_en_s;
    logic [BYTE_W-1:0]     readdata_s;

    logic                  mem_read_r;
    logic                  mem_write_r;
    logic [MEM_ADDR_W-1:0] mem_address_r;
    logic [MEM_ADDR_W-1:0] mem_address_s;
    logic [BLOCK_W-1:0]    mem_writedata_r;
    logic [BLOCK_W-1:0]    mem_writedata_s;

    assign tag_s    = bus.address[7:5];
    assign index_s  = bus.address[4:2];
    assign offset_s = bus.address[1:0];

    assign hit_s       = valid_r[index_s] && (tag_array_r[index_s] == tag_s);
    assign access_s    = bus.read || bus.write;
    assign idle_hit_s  = (state_r == IDLE) && hit_s;
    assign write_hit_s = idle_hit_s && bus.write;
    assign refill_s    = (state_r == FETCH) && !bus.mem_busywait;
    // A simultaneous read and write is a store, so no load data is returned.
    assign rd_en_s     = idle_hit_s && bus.read && !bus.write;

    // Reset gates the stall so the CPU is released as soon as reset asserts.
    assign bus.busywait      = reset && access_s && !idle_hit_s;
    assign bus.readdata      = readdata_s;
    assign bus.mem_read      = mem_read_r;
    assign bus.mem_write     = mem_write_r;
    assign bus.mem_address   = mem_address_r;
    assign bus.mem_writedata = mem_writedata_r;

    dcache_byte_sel u_byte_sel (
        .block    (data_array_r[index_s]),
        .offset   (offset_s),
        .en       (rd_en_s),
        .sel_byte (readdata_s)
    );

    // Next-state logic: miss goes to WRITEBACK when the victim is dirty, else FETCH.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (access_s && !hit_s) begin
                    if (valid_r[index_s] && dirty_r[index_s]) begin
                        state_s = WRITEBACK;
                    end else begin
                        state_s = FETCH;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WRITEBACK: begin
                if (!bus.mem_busywait) begin
                    state_s = FETCH;
                end else begin
                    state_s = WRITEBACK;
                end
            end
            FETCH: begin
                if (!bus.mem_busywait) begin
                    state_s = IDLE;
                end else begin
                    state_s = FETCH;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Memory request address/data for the state being entered.
    always_comb begin
        mem_address_s   = 6'd0;
        mem_writedata_s = 32'd0;
        case (state_s)
            WRITEBACK: begin
                mem_address_s   = {tag_array_r[index_s], index_s};
                mem_writedata_s = data_array_r[index_s];
            end
            FETCH: begin
                mem_address_s   = {tag_s, index_s};
                mem_writedata_s = 32'd0;
            end
            default: begin
                mem_address_s   = 6'd0;
                mem_writedata_s = 32'd0;
            end
        endcase
    end

    // State register and registered memory request outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r         <= IDLE;
            mem_read_r      <= 1'b0;
            mem_write_r     <= 1'b0;
            mem_address_r   <= 6'd0;
            mem_writedata_r <= 32'd0;
        end else begin
            state_r         <= state_s;
            mem_read_r      <= (state_s == FETCH);
            mem_write_r     <= (state_s == WRITEBACK);
            mem_address_r   <= mem_address_s;
            mem_writedata_r <= mem_writedata_s;
        end
    end

    // Valid/dirty bookkeeping: refill leaves a clean line, a store hit dirties it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_r <= 8'h00;
            dirty_r <= 8'h00;
        end else if (refill_s) begin
            valid_r[index_s] <= 1'b1;
            dirty_r[index_s] <= 1'b0;
        end else if (write_hit_s) begin
            dirty_r[index_s] <= 1'b1;
        end else begin
            valid_r <= valid_r;
            dirty_r <= dirty_r;
        end
    end

    // Tag and data storage, deliberately not cleared by reset.
    always_ff @(posedge clock) begin
        if (refill_s) begin
            data_array_r[index_s] <= bus.mem_readdata;
            tag_array_r[index_s]  <= tag_s;
        end else if (write_hit_s) begin
            data_array_r[index_s] <= merge_byte(data_array_r[index_s], offset_s, bus.writedata);
        end else begin
            data_array_r[index_s] <= data_array_r[index_s];
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: transaction-level cache model,
// a latency-configurable memory responder and a per-cycle compare process.
module tb_dcache_controller;

    localparam int LAT = 5;

    logic clock;
    logic reset;
    dcache_if bus ();

    dcache_controller dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    bit          m_valid [8];
    bit          m_dirty [8];
    logic [2:0]  m_tag   [8];
    logic [31:0] m_data  [8];
    logic [31:0] ref_mem [64];
    logic [31:0] mem_arr [64];

    // Expectations for the access in flight.
    bit          chk_en     = 1'b0;
    bit          acc_active = 1'b0;
    bit          acc_done   = 1'b0;
    bit          exp_wb;
    bit          exp_fetch;
    logic [5:0]  exp_wb_addr;
    logic [31:0] exp_wb_data;
    logic [5:0]  exp_fetch_addr;
    logic [7:0]  exp_rdata;
    int          exp_busy;
    int          busy_cnt;
    int          last_busy;
    logic [7:0]  last_rdata;
    logic [31:0] last_wb_data;
    logic [5:0]  last_fetch_addr;
    int          rsp_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory: LAT busy cycles, then one ready cycle per request.
    always @(negedge clock) begin
        if (bus.mem_read || bus.mem_write) begin
            if (rsp_cnt >= LAT) begin
                bus.mem_busywait = 1'b0;
                bus.mem_readdata = mem_arr[bus.mem_address];
                if (bus.mem_write) mem_arr[bus.mem_address] = bus.mem_writedata;
                rsp_cnt = 0;
            end else begin
                bus.mem_busywait = 1'b1;
                rsp_cnt++;
            end
        end else begin
            bus.mem_busywait = 1'b1;
            rsp_cnt = 0;
        end
    end

    // Per-cycle comparison of DUT outputs against the model's expectations.
    always @(negedge clock) begin
        if (chk_en) begin
            check("mem_excl", {31'd0, bus.mem_read & bus.mem_write}, 32'd0);
            if (!bus.read) check("rdata_zero", {24'd0, bus.readdata}, 32'd0);
            if (!acc_active) begin
                check("idle_busy", {31'd0, bus.busywait}, 32'd0);
                check("idle_mreq", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
            end else if (!acc_done) begin
                if (bus.mem_write) begin
                    check("wb_expected", {31'd0, exp_wb}, 32'd1);
                    check("wb_addr", {26'd0, bus.mem_address}, {26'd0, exp_wb_addr});
                    check("wb_data", bus.mem_writedata, exp_wb_data);
                    last_wb_data = bus.mem_writedata;
                end
                if (bus.mem_read) begin
                    check("fetch_expected", {31'd0, exp_fetch}, 32'd1);
                    check("fetch_addr", {26'd0, bus.mem_address}, {26'd0, exp_fetch_addr});
                    last_fetch_addr = bus.mem_address;
                end
                if (bus.busywait) begin
                    busy_cnt++;
                end else begin
                    check("latency", busy_cnt, exp_busy);
                    last_busy = busy_cnt;
                    if (bus.read && !bus.write) begin
                        check("rdata", {24'd0, bus.readdata}, {24'd0, exp_rdata});
                        last_rdata = bus.readdata;
                    end
                    acc_done = 1'b1;
                end
            end
        end
    end

    // Compute expected behaviour of one access from the cache rules, update model.
    task automatic model_access(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] wd);
        logic [2:0]  idx;
        logic [2:0]  tg;
        logic [1:0]  off;
        int          txns;
        logic [31:0] blk;
        idx = a[4:2];
        tg  = a[7:5];
        off = a[1:0];
        txns = 0;
        exp_wb = 1'b0;
        exp_fetch = 1'b0;
        if (!(m_valid[idx] && m_tag[idx] == tg)) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                exp_wb = 1'b1;
                exp_wb_addr = {m_tag[idx], idx};
                exp_wb_data = m_data[idx];
                ref_mem[{m_tag[idx], idx}] = m_data[idx];
                txns++;
            end
            exp_fetch = 1'b1;
            exp_fetch_addr = {tg, idx};
            txns++;
            m_data[idx]  = ref_mem[{tg, idx}];
            m_tag[idx]   = tg;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
        end
        blk = m_data[idx];
        exp_rdata = 8'((blk >> (8 * off)) & 32'hFF);
        if (wr) begin
            blk[8*off +: 8] = wd;
            m_data[idx]  = blk;
            m_dirty[idx] = 1'b1;
        end
        exp_busy = (txns == 0) ? 0 : txns * (LAT + 1) + 1;
    endtask

    // Issue one access (called just after a rising edge), wait for it, check literals.
    task automatic do_access(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                             input int lit_busy, input bit chk_rd, input logic [7:0] lit_rd);
        bit got;
        model_access(rd, wr, a, wd);
        bus.read = rd;
        bus.write = wr;
        bus.address = a;
        bus.writedata = wd;
        busy_cnt = 0;
        acc_done = 1'b0;
        acc_active = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clock);
            if (acc_done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("timeout", 32'd0, 32'd1);
        #1;
        bus.read = 1'b0;
        bus.write = 1'b0;
        acc_active = 1'b0;
        check("lit_busy", last_busy, lit_busy);
        if (chk_rd) check("lit_rdata", {24'd0, last_rdata}, {24'd0, lit_rd});
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem_arr[i] = 32'hA5000000 ^ (32'(i) * 32'h01030507);
        end
        mem_arr[0]    = 32'hDDCCBBAA;
        mem_arr[8]    = 32'h11223344;
        mem_arr[6'h13] = 32'h87654321;
        for (int i = 0; i < 64; i++) ref_mem[i] = mem_arr[i];
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = 3'd0;
            m_data[i]  = 32'd0;
        end
        bus.read = 1'b0;
        bus.write = 1'b0;
        bus.address = 8'h00;
        bus.writedata = 8'h00;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_busywait", {31'd0, bus.busywait}, 32'd0);
        check("rst_readdata", {24'd0, bus.readdata}, 32'd0);
        check("rst_mem_read", {31'd0, bus.mem_read}, 32'd0);
        check("rst_mem_write", {31'd0, bus.mem_write}, 32'd0);
        check("rst_mem_addr", {26'd0, bus.mem_address}, 32'd0);
        check("rst_mem_wdata", bus.mem_writedata, 32'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk_en = 1'b1;

        do_access(1'b1, 1'b0, 8'h00, 8'h00, 7, 1'b1, 8'hAA);
        check("lit_fetch0", {26'd0, last_fetch_addr}, 32'h00);
        do_access(1'b1, 1'b0, 8'h03, 8'h00, 0, 1'b1, 8'hDD);
        do_access(1'b0, 1'b1, 8'h01, 8'h55, 0, 1'b0, 8'h00);
        do_access(1'b1, 1'b0, 8'h01, 8'h00, 0, 1'b1, 8'h55);
        do_access(1'b1, 1'b0, 8'h20, 8'h00, 13, 1'b1, 8'h44);
        check("lit_wb_data", last_wb_data, 32'hDDCC55AA);
        check("lit_fetch08", {26'd0, last_fetch_addr}, 32'h08);
        do_access(1'b0, 1'b1, 8'h4E, 8'h7F, 7, 1'b0, 8'h00);
        check("lit_fetch13", {26'd0, last_fetch_addr}, 32'h13);
        do_access(1'b1, 1'b0, 8'h4E, 8'h00, 0, 1'b1, 8'h7F);
        do_access(1'b1, 1'b0, 8'h4F, 8'h00, 0, 1'b1, 8'h87);
        do_access(1'b1, 1'b0, 8'h4C, 8'h00, 0, 1'b1, 8'h21);
        do_access(1'b1, 1'b0, 8'h00, 8'h00, 7, 1'b1, 8'hAA);
        do_access(1'b1, 1'b0, 8'h01, 8'h00, 0, 1'b1, 8'h55);
        do_access(1'b0, 1'b1, 8'h6D, 8'h9C, 13, 1'b0, 8'h00);
        check("lit_wb_set3", last_wb_data, 32'h877F4321);
        check("lit_fetch1b", {26'd0, last_fetch_addr}, 32'h1B);
        do_access(1'b1, 1'b0, 8'h4E, 8'h00, 13, 1'b1, 8'h7F);
        do_access(1'b1, 1'b1, 8'h04, 8'h3C, 7, 1'b0, 8'h00);
        do_access(1'b1, 1'b0, 8'h04, 8'h00, 0, 1'b1, 8'h3C);

        // Reset in the middle of a fetch.
        chk_en = 1'b0;
        bus.read = 1'b1;
        bus.address = 8'h08;
        repeat (3) @(posedge clock);
        #1;
        check("pre_rst_mem_read", {31'd0, bus.mem_read}, 32'd1);
        reset = 1'b0;
        #1;
        check("midrst_mem_read", {31'd0, bus.mem_read}, 32'd0);
        check("midrst_busywait", {31'd0, bus.busywait}, 32'd0);
        check("midrst_mem_addr", {26'd0, bus.mem_address}, 32'd0);
        @(posedge clock);
        #1;
        bus.read = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        @(posedge clock);
        #1;
        chk_en = 1'b1;
        do_access(1'b1, 1'b0, 8'h08, 8'h00, 7, 1'b0, 8'h00);
        do_access(1'b1, 1'b0, 8'h00, 8'h00, 7, 1'b1, 8'hAA);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
